// File: rtl/spi_slave_core_pkg.sv
// Shared types and constants for the SPI mode-0 register slave.
//   state_t       : frame FSM states
//   CMD_BITS      : command byte length (RW bit + address)
//   RW_WRITE      : value of cmd[7] that selects a write
//   DEVICE_ID_DEF : default read-only contents of register 0
package spi_slave_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  localparam int         CMD_BITS      = 8;
  localparam logic       RW_WRITE      = 1'b1;
  localparam logic [7:0] DEVICE_ID_DEF = 8'hA5;
endpackage

// File: rtl/spi_slave_core_if.sv
// SPI pin bundle.
//   sclk : serial clock, idle low (master -> slave)
//   sdi  : MOSI (master -> slave)
//   csz  : chip select, active low (master -> slave)
//   sdo  : MISO (slave -> master)
interface spi_slave_core_if;
  logic sclk;
  logic sdi;
  logic csz;
  logic sdo;
  modport slave  (input sclk, input sdi, input csz, output sdo);
  modport master (output sclk, output sdi, output csz, input sdo);
endinterface

// File: rtl/spi_sync_edge.sv
// N-flop synchroniser with single-clk rise/fall pulses on the synced level.
//   clk, rst  : system clock, async active-high reset
//   i_async   : asynchronous input
//   o_level   : synchronised level
//   o_rise    : one-clk pulse on synced 0->1
//   o_fall    : one-clk pulse on synced 1->0
module spi_sync_edge #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [N-1:0] r_sync;
  logic         r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {N{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[N-2:0], i_async};
      r_prev <= r_sync[N-1];
    end
  end

  assign o_level = r_sync[N-1];
  assign o_rise  =  r_sync[N-1] & ~r_prev;
  assign o_fall  = ~r_sync[N-1] &  r_prev;
endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 slave giving an external master read/write access to a small
// register file. All SPI pins are synchronised into clk; the FSM acts on
// synced sclk edges (rise = sample sdi, fall = drive next sdo bit).
// Frame: cmd[7]=RW (1=write), cmd[6:0]=address, then DATA_W data bits, MSB first.
//   clk     : system clock
//   reset_n : async reset, ACTIVE HIGH (1 = reset)
//   spi     : sclk/sdi/csz in, sdo out (slave modport)
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 7,
  parameter int                NUM_REGS  = 8,
  parameter logic [DATA_W-1:0] DEVICE_ID = DEVICE_ID_DEF,
  parameter int                SYNC_STG  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  spi_slave_core_if.slave     spi
);
  localparam int MAXB  = (DATA_W > CMD_BITS) ? DATA_W : CMD_BITS;
  localparam int CNT_W = $clog2(MAXB);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic w_rst;
  assign w_rst = reset_n;

  // synchronisers
  logic w_sck_rise, w_sck_fall, w_sck_lvl;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic [SYNC_STG-1:0] r_sdi_sync;
  logic w_sdi;

  spi_sync_edge #(.N(SYNC_STG), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(w_rst), .i_async(spi.sclk),
    .o_level(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  // csz resets to deselected so release of reset never looks like a frame start
  spi_sync_edge #(.N(SYNC_STG), .RST_VAL(1'b1)) u_csz (
    .clk(clk), .rst(w_rst), .i_async(spi.csz),
    .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  // sdi goes through the same depth so it stays aligned with the sclk edge
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) r_sdi_sync <= '0;
    else       r_sdi_sync <= {r_sdi_sync[SYNC_STG-2:0], spi.sdi};
  end
  assign w_sdi = r_sdi_sync[SYNC_STG-1];

  // state
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_cmd;     // first 7 cmd bits; the 8th arrives live on w_sdi
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-2:0]   r_rx;      // first DATA_W-1 data bits; last arrives live
  logic [DATA_W-1:0]   r_tx;
  logic                r_sdo;
  logic [DATA_W-1:0]   r_regs [1:NUM_REGS-1];

  // address completed by the 8th rise, used to fetch read data in that same clk
  logic [ADDR_W-1:0]   w_addr_in;
  logic [DATA_W-1:0]   w_rd_data;
  logic [DATA_W-1:0]   w_wr_data;
  logic                w_wr_ok;

  assign w_addr_in = {r_cmd[ADDR_W-2:0], w_sdi};
  assign w_wr_data = {r_rx, w_sdi};
  assign w_wr_ok   = (r_rw == RW_WRITE) && (r_addr != '0) &&
                     (r_addr < ADDR_W'(NUM_REGS));

  always_comb begin
    w_rd_data = '0;
    if (w_addr_in == '0)
      w_rd_data = DEVICE_ID;
    else if (w_addr_in < ADDR_W'(NUM_REGS))
      w_rd_data = r_regs[w_addr_in[IDX_W-1:0]];
  end

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cmd   <= '0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_rx    <= '0;
      r_tx    <= '0;
      r_sdo   <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_cs_lvl) begin
      // deselected: covers idle, normal end of frame and mid-frame abort
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sdo   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sdo <= 1'b0;
          if (w_cs_fall) begin
            r_state <= CMD;
            r_cnt   <= '0;
          end
        end
        CMD: begin
          r_sdo <= 1'b0;
          if (w_sck_rise) begin
            r_cmd <= w_addr_in;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(CMD_BITS-1)) begin
              r_state <= DATA;
              r_cnt   <= '0;
              r_rw    <= r_cmd[ADDR_W-1];
              r_addr  <= w_addr_in;
              r_tx    <= (r_cmd[ADDR_W-1] == RW_WRITE) ? '0 : w_rd_data;
            end
          end
        end
        DATA: begin
          if (w_sck_rise) begin
            r_rx  <= w_wr_data[DATA_W-2:0];
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DATA_W-1)) begin
              r_state <= DONE;
              r_sdo   <= 1'b0;
              if (w_wr_ok) r_regs[r_addr[IDX_W-1:0]] <= w_wr_data;
            end
          end else if (w_sck_fall && r_rw != RW_WRITE) begin
            r_sdo <= r_tx[DATA_W-1];
            r_tx  <= {r_tx[DATA_W-2:0], 1'b0};
          end
        end
        DONE: r_sdo <= 1'b0;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign spi.sdo = r_sdo;

  // synced sclk level and csz rise are not needed beyond edge detection
  logic w_unused;
  assign w_unused = w_sck_lvl ^ w_cs_rise;
endmodule

// File: tb/tb_spi_slave_core.sv
module tb_spi_slave_core;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   chk = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  spi_slave_core_if sif();

  spi_slave_core dut (.clk(clk), .reset_n(reset_n), .spi(sif.slave));

  // reference register file: plain array, reads/writes by address rules
  logic [7:0] mregs [8];

  function automatic logic [7:0] model_read(input logic [6:0] a);
    if (a == 7'd0) return 8'hA5;
    if (a < 7'd8)  return mregs[a[2:0]];
    return 8'h00;
  endfunction

  task automatic model_write(input logic [6:0] a, input logic [7:0] d);
    if (a != 7'd0 && a < 7'd8) mregs[a[2:0]] = d;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI frame with 4-clk half periods. Captures sdo on rises 9..nbits,
  // and flags any nonzero sdo seen in the cmd phase or during extra clocks.
  task automatic frame(input logic [7:0] cmd, input logic [7:0] wd,
                       input int nbits, input int extra, input bit keep_cs,
                       output logic [7:0] rd, output bit quiet);
    rd = 8'h00;
    quiet = 1'b1;
    sif.csz = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      sif.sdi = (i < 8) ? cmd[7-i] : wd[15-i];
      wait_clk(4);
      if (i < 8) begin
        if (sif.sdo !== 1'b0) quiet = 1'b0;
      end else begin
        rd = {rd[6:0], sif.sdo};
      end
      sif.sclk = 1'b1;
      wait_clk(4);
      sif.sclk = 1'b0;
    end
    for (int i = 0; i < extra; i++) begin
      sif.sdi = 1'b1;
      wait_clk(4);
      if (sif.sdo !== 1'b0) quiet = 1'b0;
      sif.sclk = 1'b1;
      wait_clk(4);
      sif.sclk = 1'b0;
    end
    if (!keep_cs) begin
      wait_clk(4);
      sif.csz = 1'b1;
      wait_clk(4);
    end
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] wd;
    int         nbits;
    int         extra;
    logic [7:0] exp;   // bits seen on sdo during data phase
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [7:0] rd;
    bit         quiet;
    sif.sclk = 1'b0;
    sif.sdi  = 1'b0;
    sif.csz  = 1'b1;

    tbl[0]  = '{8'h82, 8'h5C, 16, 0, 8'h00};  // write 0x5C -> reg2
    tbl[1]  = '{8'h02, 8'h00, 16, 0, 8'h5C};  // read reg2
    tbl[2]  = '{8'h00, 8'h00, 16, 0, 8'hA5};  // read ID
    tbl[3]  = '{8'h80, 8'hFF, 16, 0, 8'h00};  // write reg0 ignored
    tbl[4]  = '{8'h00, 8'h00, 16, 0, 8'hA5};  // ID unchanged
    tbl[5]  = '{8'hC0, 8'h33, 16, 0, 8'h00};  // write out of range
    tbl[6]  = '{8'h40, 8'h00, 16, 0, 8'h00};  // read out of range
    tbl[7]  = '{8'h85, 8'h77, 12, 0, 8'h00};  // aborted write reg5
    tbl[8]  = '{8'h05, 8'h00, 16, 0, 8'h00};  // reg5 still 0
    tbl[9]  = '{8'h85, 8'h77, 16, 0, 8'h00};  // full write reg5
    tbl[10] = '{8'h05, 8'h00, 16, 0, 8'h77};
    tbl[11] = '{8'h83, 8'h11, 16, 8, 8'h00};  // extra sclk in DONE
    tbl[12] = '{8'h03, 8'h00, 16, 8, 8'h11};
    tbl[13] = '{8'h02, 8'h00, 16, 0, 8'h5C};  // reg2 survived out-of-range write

    wait_clk(5);
    check("reset_sdo", {31'd0, sif.sdo}, 32'd0);
    reset_n = 1'b0;
    wait_clk(3);
    check("post_reset_sdo", {31'd0, sif.sdo}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      frame(tbl[i].cmd, tbl[i].wd, tbl[i].nbits, tbl[i].extra, 1'b0, rd, quiet);
      if (tbl[i].nbits == 16)
        check($sformatf("tbl%0d_data", i), {24'd0, rd}, {24'd0, tbl[i].exp});
      check($sformatf("tbl%0d_quiet", i), {31'd0, quiet}, 32'd1);
    end

    // reset in the middle of a read, while sdo is driving a 1
    frame(8'h83, 8'h3C, 16, 0, 1'b0, rd, quiet);
    frame(8'h00, 8'h00, 10, 0, 1'b1, rd, quiet);
    wait_clk(4);
    check("midread_sdo_hi", {31'd0, sif.sdo}, 32'd1);
    reset_n = 1'b1;
    #1;
    check("midread_reset_sdo", {31'd0, sif.sdo}, 32'd0);
    sif.csz = 1'b1;
    wait_clk(3);
    reset_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    frame(8'h03, 8'h00, 16, 0, 1'b0, rd, quiet);
    check("reset_reg3", {24'd0, rd}, 32'd0);
    frame(8'h05, 8'h00, 16, 0, 1'b0, rd, quiet);
    check("reset_reg5", {24'd0, rd}, 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      logic       rw;
      logic [6:0] a;
      logic [7:0] d;
      int         r, nb, ex;
      rw = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 11);
      a  = (r < 10) ? 7'(r) : 7'(8'h40 + r);
      d  = 8'($urandom);
      nb = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 15) : 16;
      ex = $urandom_range(0, 1) * 8;
      frame({rw, a}, d, nb, ex, 1'b0, rd, quiet);
      check($sformatf("rnd%0d_quiet", n), {31'd0, quiet}, 32'd1);
      if (nb == 16) begin
        if (rw) begin
          check($sformatf("rnd%0d_wr_sdo", n), {24'd0, rd}, 32'd0);
          model_write(a, d);
        end else begin
          check($sformatf("rnd%0d_rd_a%0h", n, a), {24'd0, rd}, {24'd0, model_read(a)});
        end
      end
    end

    // final sweep of every implemented register plus one unimplemented
    for (int a = 0; a < 9; a++) begin
      frame({1'b0, 7'(a)}, 8'h00, 16, 0, 1'b0, rd, quiet);
      check($sformatf("sweep_a%0d", a), {24'd0, rd}, {24'd0, model_read(7'(a))});
    end

    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end

  // absolute time bound so the run always ends
  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded time bound");
    fails++;
    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $fatal(1);
  end
endmodule
